// File: rtl/db15_joy_responder.sv
// Device side of the DB15 dual-joystick serial link: emulates the adapter's 74HC165 chain,
// shifting two active-high 12-bit words out active-low. `DB15_RESP_TIMEOUT_EN adds a SHIFT watchdog.
module db15_joy_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 24,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] joystick1,
  input  logic [11:0] joystick2,
  input  logic        JOY_CLK,
  input  logic        JOY_LOAD,
  output logic        JOY_DATA,
  output logic        busy,
  output logic        frame_done
);

  if (SYNC_STAGES < 2 || FRAME_BITS != 24 || TIMEOUT_CYC < 2) begin : g_param_chk
    $error("db15_joy_responder: unsupported parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync, r_load_sync;
  logic                   r_clk_prev, r_load_prev;
  logic                   w_clk_rise, w_load_low, w_load_rise;
  logic [FRAME_BITS-1:0]  w_par, r_shift;
  logic [4:0]             r_cnt, w_cnt_nxt;
  logic                   w_wd_expire;
  state_t                 r_state;

  // Host lines idle high, so the chains reset to 1 to avoid a phantom edge on release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_sync  <= '1;
      r_load_sync <= '1;
      r_clk_prev  <= 1'b1;
      r_load_prev <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], JOY_CLK};
      r_load_sync <= {r_load_sync[SYNC_STAGES-2:0], JOY_LOAD};
      r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
      r_load_prev <= r_load_sync[SYNC_STAGES-1];
    end
  end

  assign w_clk_rise  = r_clk_sync[SYNC_STAGES-1] & ~r_clk_prev;
  assign w_load_low  = ~r_load_sync[SYNC_STAGES-1];
  assign w_load_rise = r_load_sync[SYNC_STAGES-1] & ~r_load_prev;
  assign w_par       = ~{joystick2, joystick1};
  assign w_cnt_nxt   = (&r_cnt) ? r_cnt : r_cnt + 5'd1;

`ifdef DB15_RESP_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] r_wdog;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             r_wdog <= '0;
    else if (r_state != S_SHIFT || w_clk_rise) r_wdog <= '0;
    else                                      r_wdog <= r_wdog + WD_W'(1);
  end

  assign w_wd_expire = (r_wdog == WD_W'(TIMEOUT_CYC - 1));
`else
  assign w_wd_expire = 1'b0;
`endif

  // JOY_DATA is the shift LSB; the register holds all 1s whenever the FSM is idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_shift    <= '1;
      r_cnt      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          busy    <= 1'b0;
          r_shift <= '1;
          if (w_load_low) begin
            r_state <= S_LOAD;
            r_shift <= w_par;
            r_cnt   <= '0;
          end
        end
        S_LOAD: begin
          r_shift <= w_par;
          r_cnt   <= '0;
          if (w_load_rise) begin
            r_state <= S_SHIFT;
            busy    <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (w_load_low) begin
            r_state <= S_LOAD;
            r_shift <= w_par;
            r_cnt   <= '0;
            busy    <= 1'b0;
          end else if (w_clk_rise) begin
            r_shift <= {1'b1, r_shift[FRAME_BITS-1:1]};
            r_cnt   <= w_cnt_nxt;
            if (w_cnt_nxt == 5'(FRAME_BITS)) begin
              r_state    <= S_IDLE;
              r_shift    <= '1;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end
          end else if (w_wd_expire) begin
            r_state <= S_IDLE;
            r_shift <= '1;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_shift <= '1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign JOY_DATA = r_shift[0];

endmodule

// File: tb/tb_db15_joy_responder.sv
// Randomised bench for db15_joy_responder; the host side is driven at clk/8 and every
// serial bit is compared with a queue of expected bits built from the joystick words.
module tb_db15_joy_responder;
`ifdef DB15_RESP_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 65535;
`endif

  logic        clk = 1'b0, reset_n = 1'b1;
  logic [11:0] joystick1 = '0, joystick2 = '0;
  logic        JOY_CLK = 1'b0, JOY_LOAD = 1'b1;
  logic        JOY_DATA, busy, frame_done;

  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, last_done_cyc = -1;
  int pos = 0;
  bit exp_q[$];

  db15_joy_responder #(.SYNC_STAGES(2), .FRAME_BITS(24), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n), .joystick1(joystick1), .joystick2(joystick2),
    .JOY_CLK(JOY_CLK), .JOY_LOAD(JOY_LOAD), .JOY_DATA(JOY_DATA), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (frame_done === 1'b1) begin
    done_cnt      <= done_cnt + 1;
    last_done_cyc <= cyc;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected serial order: player 1 bits 0..11, then player 2 bits 0..11, inverted.
  task automatic build_model(input logic [11:0] a, input logic [11:0] b);
    exp_q.delete();
    for (int k = 0; k < 12; k++) exp_q.push_back(!a[k]);
    for (int k = 0; k < 12; k++) exp_q.push_back(!b[k]);
    pos = 0;
  endtask

  task automatic load_frame(input logic [11:0] a, input logic [11:0] b);
    joystick1 = a; joystick2 = b;
    JOY_LOAD = 1'b0; tick(4);
    JOY_LOAD = 1'b1; tick(4);
    build_model(a, b);
    checks++;
    if (JOY_DATA !== exp_q[0] || busy !== 1'b1) begin
      errors++;
      $display("FAIL load_bit0 data=%b busy=%b want data=%b busy=1", JOY_DATA, busy, exp_q[0]);
    end
  endtask

  task automatic shift_bits(input int n, input bit scramble);
    int d0;
    d0 = done_cnt;
    for (int k = 0; k < n; k++) begin
      JOY_CLK = 1'b1; tick(4);
      if (scramble) begin joystick1 = 12'($urandom); joystick2 = 12'($urandom); end
      JOY_CLK = 1'b0; tick(4);
      pos++;
      checks++;
      if (JOY_DATA !== exp_q[pos] || busy !== 1'b1 || done_cnt != d0) begin
        errors++;
        $display("FAIL shift_bit%0d data=%b busy=%b done=%0d want data=%b busy=1 done=%0d",
                 pos, JOY_DATA, busy, done_cnt, exp_q[pos], d0);
      end
    end
  endtask

  task automatic finish_frame();
    int n, d0;
    d0 = done_cnt;
    JOY_CLK = 1'b1; n = cyc; tick(4);
    JOY_CLK = 1'b0; tick(4);
    checks++;
    if (done_cnt != d0 + 1 || last_done_cyc != n + 3 || busy !== 1'b0 || JOY_DATA !== 1'b1) begin
      errors++;
      $display("FAIL frame_end done=%0d at cyc %0d busy=%b data=%b want done=%0d at cyc %0d busy=0 data=1",
               done_cnt, last_done_cyc, busy, JOY_DATA, d0 + 1, n + 3);
    end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      JOY_CLK = 1'b1; JOY_LOAD = k[0]; tick(3);
      JOY_CLK = 1'b0; tick(3);
    end
    JOY_LOAD = 1'b1;
    checks++;
    if (JOY_DATA !== 1'b1 || busy !== 1'b0 || done_cnt != 0) begin
      errors++;
      $display("FAIL reset_hold data=%b busy=%b done=%0d want 1 0 0", JOY_DATA, busy, done_cnt);
    end
    reset_n = 1'b1; tick(6);
    checks++;
    if (JOY_DATA !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release data=%b busy=%b fd=%b want 1 0 0", JOY_DATA, busy, frame_done);
    end
  endtask

  task automatic test_basic();
    load_frame(12'h00F, 12'h400);
    shift_bits(23, 1'b0);
    finish_frame();
  endtask

  task automatic test_idle_clk();
    int d0;
    d0 = done_cnt;
    for (int k = 0; k < 4; k++) begin
      JOY_CLK = 1'b1; tick(4); JOY_CLK = 1'b0; tick(4);
      checks++;
      if (JOY_DATA !== 1'b1 || busy !== 1'b0 || done_cnt != d0) begin
        errors++;
        $display("FAIL idle_clk data=%b busy=%b done=%0d want 1 0 %0d", JOY_DATA, busy, done_cnt, d0);
      end
    end
  endtask

  task automatic test_live_load();
    joystick1 = 12'h000; joystick2 = 12'($urandom);
    JOY_LOAD = 1'b0; tick(5);
    checks++;
    if (JOY_DATA !== 1'b1) begin
      errors++;
      $display("FAIL live_load_pre data=%b want 1", JOY_DATA);
    end
    joystick1 = 12'h001; tick(1);
    checks++;
    if (JOY_DATA !== 1'b0) begin
      errors++;
      $display("FAIL live_load_track data=%b want 0", JOY_DATA);
    end
    JOY_LOAD = 1'b1; tick(4);
    build_model(joystick1, joystick2);
    shift_bits(23, 1'b1);
    finish_frame();
  endtask

  task automatic test_random();
    for (int f = 0; f < 5; f++) begin
      load_frame(12'($urandom), 12'($urandom));
      shift_bits(23, 1'b1);
      finish_frame();
    end
  endtask

  task automatic test_reload();
    int d0;
    load_frame(12'($urandom), 12'($urandom));
    shift_bits(10, 1'b0);
    d0 = done_cnt;
    JOY_LOAD = 1'b0; tick(4);
    checks++;
    if (busy !== 1'b0 || done_cnt != d0) begin
      errors++;
      $display("FAIL reload_abort busy=%b done=%0d want 0 %0d", busy, done_cnt, d0);
    end
    joystick1 = 12'($urandom); joystick2 = 12'($urandom); tick(2);
    JOY_LOAD = 1'b1; tick(4);
    build_model(joystick1, joystick2);
    checks++;
    if (JOY_DATA !== exp_q[0] || busy !== 1'b1) begin
      errors++;
      $display("FAIL reload_bit0 data=%b busy=%b want %b 1", JOY_DATA, busy, exp_q[0]);
    end
    shift_bits(23, 1'b0);
    finish_frame();
  endtask

  task automatic test_collision();
    load_frame(12'($urandom), 12'($urandom));
    shift_bits(5, 1'b0);
    JOY_LOAD = 1'b0; JOY_CLK = 1'b1; tick(4);
    checks++;
    if (busy !== 1'b0 || JOY_DATA !== !joystick1[0]) begin
      errors++;
      $display("FAIL collision busy=%b data=%b want 0 %b", busy, JOY_DATA, !joystick1[0]);
    end
    JOY_CLK = 1'b0; tick(4);
    joystick1 = 12'($urandom); joystick2 = 12'($urandom); tick(2);
    JOY_LOAD = 1'b1; tick(4);
    build_model(joystick1, joystick2);
    shift_bits(23, 1'b0);
    finish_frame();
  endtask

  task automatic test_reset_midframe();
    int d0;
    load_frame(12'($urandom), 12'($urandom));
    shift_bits(7, 1'b0);
    d0 = done_cnt;
    reset_n = 1'b0; #1;
    checks++;
    if (JOY_DATA !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid data=%b busy=%b want 1 0", JOY_DATA, busy);
    end
    tick(2); reset_n = 1'b1; tick(2);
    for (int k = 0; k < 3; k++) begin
      JOY_CLK = 1'b1; tick(4); JOY_CLK = 1'b0; tick(4);
    end
    checks++;
    if (JOY_DATA !== 1'b1 || busy !== 1'b0 || done_cnt != d0) begin
      errors++;
      $display("FAIL reset_no_restart data=%b busy=%b done=%0d want 1 0 %0d", JOY_DATA, busy, done_cnt, d0);
    end
  endtask

  task automatic test_timeout();
    int d0;
    load_frame(12'($urandom), 12'($urandom));
    shift_bits(5, 1'b0);
    d0 = done_cnt;
    tick(150);
    checks++;
`ifdef DB15_RESP_TIMEOUT_EN
    if (busy !== 1'b0 || JOY_DATA !== 1'b1 || done_cnt != d0) begin
      errors++;
      $display("FAIL timeout busy=%b data=%b done=%0d want 0 1 %0d", busy, JOY_DATA, done_cnt, d0);
    end
`else
    if (busy !== 1'b1 || JOY_DATA !== exp_q[5] || done_cnt != d0) begin
      errors++;
      $display("FAIL no_timeout busy=%b data=%b done=%0d want 1 %b %0d", busy, JOY_DATA, done_cnt, exp_q[5], d0);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_idle_clk();
    test_live_load();
    test_random();
    test_reload();
    test_collision();
    test_reset_midframe();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
endmodule
